// File: rtl/lt24_pixel_bus_writer.sv
// lt24_pixel_bus_writer
//   Accepts one pixel per pixelWrite/pixelReady handshake and drives the
//   LT24 8080-style bus. For each pixel it sends: CASET 0x2A with four column
//   bytes, PASET 0x2B with four row bytes, RAMWR 0x2C, and one 16-bit colour word.
//   Panel power-up and init happen elsewhere and are reported on initDone.
//
//   Optional feature macro: LT24_ADDR_CACHE_EN
//     When defined, the block predicts the next raster-order address. If an
//     accepted pixel matches the prediction, only the RAMWR data word is sent.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   initDone            panel ready; no pixel is accepted while low
//   xAddr/yAddr         pixel column/row, sampled on accept
//   pixelData           RGB565 colour, sampled on accept
//   pixelWrite          request; accepted when pixelWrite & pixelReady at an edge
//   pixelReady          high when idle, initDone is high and reset is not asserted
//   LT24CS_n/RS/Wr_n    bus control (CS_n low for the whole pixel, RS 0=cmd 1=data)
//   LT24Rd_n            always 1
//   LT24Data            bus word; command and parameter bytes sit on [7:0]
module lt24_pixel_bus_writer #(
    parameter int WIDTH          = 240,
    parameter int HEIGHT         = 320,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        initDone,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic [15:0] LT24Data
);

    localparam int CNT_MAX = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] LO_END    = CW'(WR_LOW_CYCLES - 1);
    localparam logic [CW-1:0] HI_END    = CW'(WR_HIGH_CYCLES - 1);
    localparam logic [3:0]    LAST_STEP = 4'd11;
    localparam logic [15:0]   X_LAST    = 16'(WIDTH - 1);
    localparam logic [15:0]   Y_LAST    = 16'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI,
        DROP   // one-cycle dead state for out-of-range pixels
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    step, step_n;

    logic [7:0]    x_q;
    logic [8:0]    y_q;
    logic [15:0]   d_q;

    logic          accept;
    logic          in_range;
    logic          hit;
    logic          busy;
    logic [15:0]   word;
    logic          word_rs;

    assign pixelReady = (state == IDLE) && initDone && !reset;
    assign accept     = pixelWrite && pixelReady;
    assign in_range   = (16'(xAddr) < 16'(WIDTH)) && (16'(yAddr) < 16'(HEIGHT));

`ifdef LT24_ADDR_CACHE_EN
    logic       cache_valid;
    logic [7:0] pred_x;
    logic [8:0] pred_y;

    assign hit = cache_valid && (xAddr == pred_x) && (yAddr == pred_y);

    // The prediction is reloaded on every in-range accept, for hits and for
    // full sequences, so a raster stream keeps hitting. A reset mid-pixel
    // also clears valid, so an aborted pixel never leaves a stale prediction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cache_valid <= 1'b0;
            pred_x      <= '0;
            pred_y      <= '0;
        end else if (accept && in_range) begin
            cache_valid <= 1'b1;
            if (16'(xAddr) == X_LAST) begin
                pred_x <= '0;
                pred_y <= (16'(yAddr) == Y_LAST) ? 9'd0 : yAddr + 9'd1;
            end else begin
                pred_x <= xAddr + 8'd1;
                pred_y <= yAddr;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            step  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            step  <= step_n;
        end
    end

    // Next-state logic. cnt times the low and high phases of each word.
    // step indexes the word list. A cache hit starts directly at the last word.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        step_n  = step;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        state_n = DROP;
                    end else begin
                        state_n = WR_LO;
                        cnt_n   = '0;
                        step_n  = hit ? LAST_STEP : 4'd0;
                    end
                end
            end
            WR_LO: begin
                if (cnt == LO_END) begin
                    state_n = WR_HI;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WR_HI: begin
                if (cnt == HI_END) begin
                    cnt_n = '0;
                    if (step == LAST_STEP) begin
                        state_n = IDLE;
                    end else begin
                        state_n = WR_LO;
                        step_n  = step + 4'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DROP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pixel capture. Later input changes do not affect the pixel in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            d_q <= '0;
        end else if (accept) begin
            x_q <= xAddr;
            y_q <= yAddr;
            d_q <= pixelData;
        end
    end

    // Word list. Addresses are zero-extended to 16 bits, then split into bytes.
    always_comb begin
        word    = 16'h0000;
        word_rs = 1'b1;
        case (step)
            4'd0:  begin word = 16'h002A; word_rs = 1'b0; end
            4'd1:  word = 16'h0000;
            4'd2:  word = {8'h00, x_q};
            4'd3:  word = {8'h00, X_LAST[15:8]};
            4'd4:  word = {8'h00, X_LAST[7:0]};
            4'd5:  begin word = 16'h002B; word_rs = 1'b0; end
            4'd6:  word = {15'h0000, y_q[8]};
            4'd7:  word = {8'h00, y_q[7:0]};
            4'd8:  word = {8'h00, Y_LAST[15:8]};
            4'd9:  word = {8'h00, Y_LAST[7:0]};
            4'd10: begin word = 16'h002C; word_rs = 1'b0; end
            4'd11: word = d_q;
            default: begin word = 16'h0000; word_rs = 1'b1; end
        endcase
    end

    // The bus is decoded from the registered state. An asynchronous reset
    // therefore returns the pins to idle values at once.
    assign busy     = (state == WR_LO) || (state == WR_HI);
    assign LT24CS_n = !busy;
    assign LT24Wr_n = (state != WR_LO);
    assign LT24RS   = busy ? word_rs : 1'b1;
    assign LT24Data = busy ? word : 16'h0000;
    assign LT24Rd_n = 1'b1;

endmodule

// File: tb/tb_lt24_pixel_bus_writer.sv
// Bench for lt24_pixel_bus_writer. Two instances share the inputs:
// u0 uses the default timing (2 low / 2 high), and u1 uses 3 low / 1 high.
// Both have the same word period, so they run in lockstep.
module tb_lt24_pixel_bus_writer;

    localparam int W = 240;
    localparam int H = 320;
`ifdef LT24_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        initDone = 1'b0;
    logic        pixelWrite = 1'b0;
    logic [7:0]  xAddr = '0;
    logic [8:0]  yAddr = '0;
    logic [15:0] pixelData = '0;

    logic        rdy0, cs0, rs0, wr0, rd0;
    logic        rdy1, cs1, rs1, wr1, rd1;
    logic [15:0] dat0, dat1;
    logic [1:0]  rdy, cs, rs, wr, rd;
    logic [15:0] dat [2];

    assign rdy = {rdy1, rdy0};
    assign cs  = {cs1, cs0};
    assign rs  = {rs1, rs0};
    assign wr  = {wr1, wr0};
    assign rd  = {rd1, rd0};
    assign dat[0] = dat0;
    assign dat[1] = dat1;

    always #5 clock = ~clock;

    lt24_pixel_bus_writer u0 (
        .clock(clock), .reset(reset), .initDone(initDone),
        .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite),
        .pixelReady(rdy0), .LT24CS_n(cs0), .LT24RS(rs0), .LT24Wr_n(wr0),
        .LT24Rd_n(rd0), .LT24Data(dat0)
    );

    lt24_pixel_bus_writer #(.WR_LOW_CYCLES(3), .WR_HIGH_CYCLES(1)) u1 (
        .clock(clock), .reset(reset), .initDone(initDone),
        .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite),
        .pixelReady(rdy1), .LT24CS_n(cs1), .LT24RS(rs1), .LT24Wr_n(wr1),
        .LT24Rd_n(rd1), .LT24Data(dat1)
    );

    int checks = 0;
    int failures = 0;
    int lo_cyc [2] = '{2, 3};
    int period = 4;

    // reference cache: predicted raster index
    bit c_valid = 1'b0;
    int c_idx = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
        end
    endtask

    // Observes both instances from the cycle after the accept edge until
    // pixelReady returns, and checks every bus word against the model.
    task automatic monitor(input int x, input int y, input int d);
        int  ew [12];
        bit  er [12];
        int  nexp, ercyc;
        bit  inr, hit;
        int  lowc [2], start [2], nw [2], rcyc [2], csbad [2], stab [2], capd [2];
        bit  caprs [2], done [2];
        inr = (x < W) && (y < H);
        hit = CACHE && inr && c_valid && ((y * W + x) == c_idx);
        if (!inr) begin
            nexp = 0;
        end else if (hit) begin
            nexp = 1; ew[0] = d; er[0] = 1'b1;
        end else begin
            nexp = 12;
            ew = '{'h2A, 0, x, 0, 'hEF, 'h2B, y / 256, y % 256, 1, 'h3F, 'h2C, d};
            er = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        end
        if (inr && CACHE) begin
            c_valid = 1'b1;
            c_idx = (y * W + x + 1) % (W * H);
        end
        ercyc = inr ? nexp * period + 1 : 2;
        for (int s = 0; s < 2; s++) begin
            lowc[s] = 0; start[s] = 0; nw[s] = 0; rcyc[s] = 0;
            csbad[s] = 0; stab[s] = 0; capd[s] = 0; caprs[s] = 0; done[s] = 0;
        end
        for (int n = 1; n <= 80 && !(done[0] && done[1]); n++) begin
            @(negedge clock);
            for (int s = 0; s < 2; s++) begin
                if (!done[s]) begin
                    if (rdy[s]) begin
                        done[s] = 1'b1;
                        rcyc[s] = n;
                    end else begin
                        if (cs[s] != ((nexp > 0) ? 1'b0 : 1'b1)) csbad[s]++;
                        if (!wr[s]) begin
                            if (lowc[s] == 0) begin
                                start[s] = n; capd[s] = int'(dat[s]); caprs[s] = rs[s];
                            end else if (int'(dat[s]) != capd[s] || rs[s] != caprs[s]) begin
                                stab[s]++;
                            end
                            lowc[s]++;
                        end else if (lowc[s] > 0) begin
                            if (nw[s] < nexp) begin
                                chk($sformatf("word%0d_u%0d", nw[s], s), capd[s], ew[nw[s]]);
                                chk($sformatf("rs%0d_u%0d", nw[s], s), caprs[s], er[nw[s]]);
                                chk($sformatf("start%0d_u%0d", nw[s], s), start[s], 1 + nw[s] * period);
                                chk($sformatf("lowlen%0d_u%0d", nw[s], s), lowc[s], lo_cyc[s]);
                                chk($sformatf("hold%0d_u%0d", nw[s], s), dat[s], capd[s]);
                            end
                            nw[s]++;
                            lowc[s] = 0;
                        end
                    end
                end
            end
            if (done[0] || done[1]) pixelWrite = 1'b0;
        end
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("nwords_u%0d", s), nw[s], nexp);
            chk($sformatf("ready_cyc_u%0d", s), rcyc[s], ercyc);
            chk($sformatf("cs_u%0d", s), csbad[s], 0);
            chk($sformatf("stable_u%0d", s), stab[s], 0);
        end
        chk("rd_n", rd, 2'b11);
    endtask

    // hold=1 keeps pixelWrite high with junk inputs while the pixel is busy.
    // Those requests must be ignored.
    task automatic do_pixel(input int x, input int y, input int d, input bit hold);
        @(negedge clock);
        xAddr = 8'(x); yAddr = 9'(y); pixelData = 16'(d); pixelWrite = 1'b1;
        #1 chk("ready_pre", rdy, 2'b11);
        @(posedge clock);
        #1;
        if (!hold) pixelWrite = 1'b0;
        xAddr = 8'($urandom); yAddr = 9'($urandom); pixelData = 16'($urandom);
        monitor(x, y, d);
    endtask

    initial begin
        int x, y;
        // reset state
        #1;
        chk("rst_cs", cs, 2'b11);
        chk("rst_wr", wr, 2'b11);
        chk("rst_rs", rs, 2'b11);
        chk("rst_dat", {dat1, dat0}, 32'h0);
        chk("rst_rdy", rdy, 2'b00);
        initDone = 1'b1;
        #1 chk("rst_rdy_init", rdy, 2'b00);
        @(negedge clock) reset = 1'b0;
        #1 chk("post_rst_rdy", rdy, 2'b11);

        // directed full sequence
        do_pixel(10, 20, 'hF800, 1'b0);

        // out-of-range pixels
        do_pixel(240, 7, 'h1234, 1'b0);
        do_pixel(3, 320, 'h5678, 1'b1);

        // initDone gating
        @(negedge clock);
        initDone = 1'b0;
        xAddr = 8'd3; yAddr = 9'd4; pixelData = 16'h1234; pixelWrite = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("nodone_rdy", rdy, 2'b00);
            chk("nodone_wr", wr, 2'b11);
            chk("nodone_cs", cs, 2'b11);
        end
        initDone = 1'b1;
        #1 chk("done_rdy", rdy, 2'b11);
        @(posedge clock);
        #1 pixelWrite = 1'b0;
        monitor(3, 4, 'h1234);

        // raster-order sequence, then a jump, then a full-frame wrap
        do_pixel(239, 0, 'h07E0, 1'b0);
        do_pixel(0, 1, 'h001F, 1'b0);
        do_pixel(5, 5, 'hFFFF, 1'b0);
        do_pixel(239, 319, 'hABCD, 1'b0);
        do_pixel(0, 0, 'h4321, 1'b1);

        // reset during word 5: both instances have word 5 low in cycle 22
        @(negedge clock);
        xAddr = 8'd10; yAddr = 9'd20; pixelData = 16'hF800; pixelWrite = 1'b1;
        @(posedge clock);
        #1 pixelWrite = 1'b0;
        repeat (22) @(negedge clock);
        chk("mid_wr_low", wr, 2'b00);
        reset = 1'b1;
        #1;
        chk("abort_cs", cs, 2'b11);
        chk("abort_wr", wr, 2'b11);
        chk("abort_dat", {dat1, dat0}, 32'h0);
        chk("abort_rdy", rdy, 2'b00);
        c_valid = 1'b0;
        @(negedge clock) reset = 1'b0;
        #1 chk("abort_release_rdy", rdy, 2'b11);

        // randomized pixels; some reuse the predicted next address
        for (int i = 0; i < 40; i++) begin
            if (c_valid && $urandom_range(0, 2) == 0) begin
                x = c_idx % W;
                y = c_idx / W;
            end else begin
                x = $urandom_range(0, 250);
                y = $urandom_range(0, 330);
            end
            do_pixel(x, y, int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
